// File: rtl/bmp180_poll_seq_if.sv
// I2C_BMP180 command/data bus seen by the polling sequencer.
// master: sequencer (drives sw* strobes); slave: I2C controller.
interface bmp180_poll_seq_if;
  logic       ready;
  logic [7:0] data;
  logic       received;
  logic       swTemp;
  logic       swGTemp;
  logic       swPress;
  logic       swGPress;

  modport master (
    input  ready,
    input  data,
    input  received,
    output swTemp,
    output swGTemp,
    output swPress,
    output swGPress
  );

  modport slave (
    output ready,
    output data,
    output received,
    input  swTemp,
    input  swGTemp,
    input  swPress,
    input  swGPress
  );
endinterface

// File: rtl/bmp180_poll_seq.sv
// Periodic BMP180 temperature/pressure poller driving I2C_BMP180.
// Ports: clk, reset (async, active-high), enable, bus (I2C side),
//   ut/up (last raw readings), valid, busy, err (sticky).
module bmp180_poll_seq #(
  parameter int PERIOD  = 50000000,
  parameter int T_WAIT  = 225000,
  parameter int P_WAIT  = 1275000,
  parameter int TIMEOUT = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  bmp180_poll_seq_if.master    bus,
  output logic [15:0]          ut,
  output logic [15:0]          up,
  output logic                 valid,
  output logic                 busy,
  output logic                 err
);

  localparam int WMAX = (T_WAIT > P_WAIT) ? T_WAIT : P_WAIT;
  localparam int PW   = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int WW   = $clog2(WMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, CMD_T, XFER_T, CONV_T, GET_T, XFER_GT,
    CMD_P, XFER_P, CONV_P, GET_P, XFER_GP, DONE
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [PW-1:0]  pcnt;
  logic [TW-1:0]  tcnt;
  logic [WW-1:0]  wcnt;
  logic           seen_low;
  logic [1:0]     idx;
  logic [15:0]    tsh;
  logic [15:0]    psh;

  logic tick;
  logic is_xfer;
  logic is_conv;
  logic is_gx;
  logic xfer_end;
  logic tmo;
  logic stay;
  logic set_err;
  logic clr_err;
  logic load_out;

  assign tick    = (pcnt == PW'(PERIOD - 1));
  assign is_xfer = (state == XFER_T) || (state == XFER_GT) ||
                   (state == XFER_P) || (state == XFER_GP);
  assign is_conv = (state == CONV_T) || (state == CONV_P);
  assign is_gx   = (state == XFER_GT) || (state == XFER_GP);
  // A transaction is over only after ready was seen low, then high.
  assign xfer_end = is_xfer && seen_low && bus.ready;
  assign tmo      = is_xfer && (tcnt == TW'(TIMEOUT - 1));
  assign stay     = (nxt == state);

  assign valid = (state == DONE);
  assign busy  = (state != IDLE);

  always_comb begin
    nxt          = state;
    bus.swTemp   = 1'b0;
    bus.swGTemp  = 1'b0;
    bus.swPress  = 1'b0;
    bus.swGPress = 1'b0;
    set_err      = 1'b0;
    clr_err      = 1'b0;
    load_out     = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick && enable && bus.ready) begin
          nxt     = CMD_T;
          clr_err = 1'b1;
        end
      end
      CMD_T: begin
        bus.swTemp = 1'b1;
        nxt        = XFER_T;
      end
      XFER_T: begin
        if (xfer_end) begin
          nxt = CONV_T;
        end else if (tmo) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      CONV_T: begin
        if (wcnt == WW'(T_WAIT - 1)) nxt = GET_T;
      end
      GET_T: begin
        bus.swGTemp = 1'b1;
        nxt         = XFER_GT;
      end
      XFER_GT: begin
        if (xfer_end) begin
          if (idx == 2'd2) begin
            nxt = CMD_P;
          end else begin
            set_err = 1'b1;
            nxt     = IDLE;
          end
        end else if (tmo) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      CMD_P: begin
        bus.swPress = 1'b1;
        nxt         = XFER_P;
      end
      XFER_P: begin
        if (xfer_end) begin
          nxt = CONV_P;
        end else if (tmo) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      CONV_P: begin
        if (wcnt == WW'(P_WAIT - 1)) nxt = GET_P;
      end
      GET_P: begin
        bus.swGPress = 1'b1;
        nxt          = XFER_GP;
      end
      XFER_GP: begin
        if (xfer_end) begin
          if (idx == 2'd2) begin
            nxt      = DONE;
            load_out = 1'b1;
          end else begin
            set_err = 1'b1;
            nxt     = IDLE;
          end
        end else if (tmo) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt     <= '0;
      tcnt     <= '0;
      wcnt     <= '0;
      seen_low <= 1'b0;
      idx      <= '0;
      tsh      <= '0;
      psh      <= '0;
      ut       <= '0;
      up       <= '0;
      err      <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      // Per-state counters restart whenever the state changes.
      tcnt <= (is_xfer && stay) ? tcnt + TW'(1) : '0;
      wcnt <= (is_conv && stay) ? wcnt + WW'(1) : '0;
      seen_low <= is_xfer && stay && (seen_low || !bus.ready);

      if ((state == GET_T) || (state == GET_P)) begin
        idx <= '0;
      end else if (is_gx && bus.received && (idx != 2'd2)) begin
        idx <= idx + 2'd1;
      end

      if ((state == XFER_GT) && bus.received) begin
        if (idx == 2'd0) tsh[15:8] <= bus.data;
        if (idx == 2'd1) tsh[7:0]  <= bus.data;
      end
      if ((state == XFER_GP) && bus.received) begin
        if (idx == 2'd0) psh[15:8] <= bus.data;
        if (idx == 2'd1) psh[7:0]  <= bus.data;
      end

      if (set_err) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end

      // Outputs take the shadows on entry to DONE so they are
      // already current while valid is high.
      if (load_out) begin
        ut <= tsh;
        up <= psh;
      end
    end
  end

endmodule

// File: tb/tb_bmp180_poll_seq.sv
// Scoreboard bench for bmp180_poll_seq with a behavioural
// I2C_BMP180 responder and randomized measurement scenarios.
module tb_bmp180_poll_seq;
  localparam int PERIOD  = 100;
  localparam int T_WAIT  = 10;
  localparam int P_WAIT  = 20;
  localparam int TIMEOUT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] ut;
  logic [15:0] up;
  logic        valid;
  logic        busy;
  logic        err;

  bmp180_poll_seq_if bus();

  bmp180_poll_seq #(
    .PERIOD(PERIOD), .T_WAIT(T_WAIT),
    .P_WAIT(P_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .ut(ut), .up(up), .valid(valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    bit          hang;
    logic [15:0] ut;
    logic [15:0] up;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  t_bytes[$];
  logic [7:0]  p_bytes[$];
  bit          hang_p = 0;
  logic [15:0] m_ut = 0;
  logic [15:0] m_up = 0;
  int          n_valid_exp = 0;
  int          n_valid_seen = 0;
  int          t_rise_t = -1000;
  int          t_rise_p = -1000;
  int          t_press = -1000;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference model: outcome of one measurement from the byte lists.
  function automatic void plan();
    exp_t e;
    e.hang = 0;
    if (t_bytes.size() < 2) begin
      e.is_err = 1;
    end else if (hang_p) begin
      e.is_err = 1;
      e.hang = 1;
    end else if (p_bytes.size() < 2) begin
      e.is_err = 1;
    end else begin
      e.is_err = 0;
      m_ut = 16'(t_bytes[0] * 256 + t_bytes[1]);
      m_up = 16'(p_bytes[0] * 256 + p_bytes[1]);
      n_valid_exp++;
    end
    e.ut = m_ut;
    e.up = m_up;
    q.push_back(e);
  endfunction

  // Behavioural I2C controller: ready drops after each strobe,
  // bytes stream back for read commands, then ready returns.
  initial begin
    bus.ready = 1'b1;
    bus.data = 8'h00;
    bus.received = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.swTemp || bus.swGTemp || bus.swPress || bus.swGPress) begin
        logic [7:0] b[$];
        int n;
        int cmd;
        b = {};
        cmd = bus.swTemp ? 0 : bus.swGTemp ? 1 : bus.swPress ? 2 : 3;
        if (cmd == 1) b = t_bytes;
        if (cmd == 3) b = p_bytes;
        bus.ready = 1'b0;
        if (cmd == 2 && hang_p) begin
          repeat (TIMEOUT + 20) @(negedge clk);
        end else begin
          n = (b.size() + 1 > 5) ? b.size() + 1 : 5;
          for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < b.size()) begin
              bus.data = b[k];
              bus.received = 1'b1;
            end else begin
              bus.received = 1'b0;
            end
          end
          @(negedge clk);
        end
        bus.received = 1'b0;
        bus.ready = 1'b1;
        if (cmd == 0) t_rise_t = cyc;
        if (cmd == 2) t_rise_p = cyc;
      end
    end
  end

  // Monitor: strobe rules, timing, and scoreboard pops.
  initial begin
    logic [3:0] s;
    logic [3:0] ps;
    logic       perr;
    exp_t       e;
    ps = 4'b0;
    perr = 1'b0;
    forever begin
      @(negedge clk);
      s = {bus.swTemp, bus.swGTemp, bus.swPress, bus.swGPress};
      if (s != 4'b0) begin
        chk("strobe_onehot", 32'($countones(s)), 32'd1);
        chk("strobe_width", 32'(s & ps), 32'd0);
      end
      if (bus.swGTemp) chk("t_wait_gap", 32'(cyc - t_rise_t), 32'(T_WAIT + 1));
      if (bus.swGPress) chk("p_wait_gap", 32'(cyc - t_rise_p), 32'(P_WAIT + 1));
      if (bus.swPress) t_press = cyc;
      if (valid) begin
        n_valid_seen++;
        if (q.size() == 0) begin
          fail("unexpected_valid");
        end else begin
          e = q.pop_front();
          chk("valid_expected", 32'(e.is_err), 32'd0);
          chk("ut", 32'(ut), 32'(e.ut));
          chk("up", 32'(up), 32'(e.up));
          chk("err_at_valid", 32'(err), 32'd0);
        end
      end
      if (err && !perr && !reset) begin
        if (q.size() == 0) begin
          fail("unexpected_err");
        end else begin
          e = q.pop_front();
          chk("err_expected", 32'(e.is_err), 32'd1);
          chk("ut_kept", 32'(ut), 32'(e.ut));
          chk("up_kept", 32'(up), 32'(e.up));
          if (e.hang) begin
            chk("timeout_gap",
                32'((cyc - t_press >= TIMEOUT) && (cyc - t_press <= TIMEOUT + 2)),
                32'd1);
          end
        end
      end
      ps = s;
      perr = err;
    end
  end

  task automatic wait_meas();
    int k;
    k = 0;
    while (!busy && k < 4 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    if (!busy) fail("start_timeout");
    k = 0;
    while (busy && k < 3 * TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    if (busy) fail("finish_timeout");
    k = 0;
    while (!bus.ready && k < 3 * TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    if (!bus.ready) fail("ready_timeout");
  endtask

  task automatic run_case(input logic [7:0] t0, input logic [7:0] t1,
                          input logic [7:0] p0, input logic [7:0] p1,
                          input int mode);
    t_bytes = {t0, t1};
    p_bytes = {p0, p1};
    hang_p = 0;
    case (mode)
      1: t_bytes = {t0};
      2: p_bytes = {p0};
      3: t_bytes.push_back(8'($urandom));
      4: p_bytes.push_back(8'($urandom));
      5: hang_p = 1;
      default: ;
    endcase
    plan();
    wait_meas();
  endtask

  initial begin
    int k;
    int rose;
    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ut", 32'(ut), 32'd0);
    chk("rst_up", 32'(up), 32'd0);
    chk("rst_strobes",
        32'({bus.swTemp, bus.swGTemp, bus.swPress, bus.swGPress}), 32'd0);
    reset = 1'b0;
    enable = 1'b1;

    run_case(8'h6C, 8'hFA, 8'h5D, 8'h23, 0);
    chk("ut_basic", 32'(ut), 32'h6CFA);
    chk("up_basic", 32'(up), 32'h5D23);
    t_bytes = {8'h11, 8'h22, 8'h33};
    p_bytes = {8'h44, 8'h55};
    hang_p = 0;
    plan();
    wait_meas();
    chk("ut_three_bytes", 32'(ut), 32'h1122);
    run_case(8'h01, 8'h02, 8'hAA, 8'h00, 2);
    chk("err_short_press", 32'(err), 32'd1);
    run_case(8'h12, 8'h34, 8'h56, 8'h78, 0);
    chk("err_cleared", 32'(err), 32'd0);
    run_case(8'h9A, 8'hBC, 8'hDE, 8'hF0, 5);
    chk("err_hang", 32'(err), 32'd1);
    run_case(8'h0F, 8'hF0, 8'hA5, 8'h5A, 0);

    for (int i = 0; i < 12; i++) begin
      run_case(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, 9)));
    end

    // enable dropped mid-cycle: cycle completes, no restart.
    t_bytes = {8'hC3, 8'h3C};
    p_bytes = {8'h81, 8'h18};
    hang_p = 0;
    plan();
    k = 0;
    while (!busy && k < 4 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    if (!busy) fail("en_start_timeout");
    enable = 1'b0;
    k = 0;
    while (busy && k < 3 * TIMEOUT) begin
      @(negedge clk);
      k++;
    end
    chk("en_ut", 32'(ut), 32'hC33C);
    rose = 0;
    repeat (3 * PERIOD) begin
      @(negedge clk);
      if (busy) rose = 1;
    end
    chk("no_restart", 32'(rose), 32'd0);

    // reset during CONV_P aborts at once.
    enable = 1'b1;
    t_bytes = {8'h77, 8'h66};
    p_bytes = {8'h55, 8'h44};
    k = 0;
    while (!bus.swPress && k < 4 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    if (!bus.swPress) fail("press_wait_timeout");
    repeat (12) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_ut", 32'(ut), 32'd0);
    chk("rst_mid_up", 32'(up), 32'd0);
    m_ut = 16'h0;
    m_up = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    rose = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy) rose = 1;
    end
    chk("wait_new_tick", 32'(rose), 32'd0);
    run_case(8'h2B, 8'hAD, 8'hBE, 8'hEF, 0);
    enable = 1'b0;
    repeat (2 * PERIOD) @(negedge clk);

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("valid_count", 32'(n_valid_seen), 32'(n_valid_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
